// File: rtl/multicycle_controller_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, ALU op
// classes, ALU operation codes, FSM states and datapath mux selects.
package multicycle_controller_pkg;

  // Instruction opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JR    = 6'b000110;

  // ALU op class handed to alu_controller
  localparam logic [1:0] ALU_OP_ADD  = 2'b00;
  localparam logic [1:0] ALU_OP_SUB  = 2'b01;
  localparam logic [1:0] ALU_OP_FUNC = 2'b10;
  localparam logic [1:0] ALU_OP_SLT  = 2'b11;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FUNC_ADD = 6'b100000;
  localparam logic [5:0] FUNC_SUB = 6'b100010;
  localparam logic [5:0] FUNC_AND = 6'b100100;
  localparam logic [5:0] FUNC_OR  = 6'b100101;
  localparam logic [5:0] FUNC_SLT = 6'b101010;

  // ALU operation codes driven to the ALU
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Controller states
  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_RD    = 4'd3,
    S_LW_WB     = 4'd4,
    S_MEM_WR    = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_ADDI_EXEC = 4'd8,
    S_SLTI_EXEC = 4'd9,
    S_I_WB      = 4'd10,
    S_BRANCH    = 4'd11,
    S_JUMP      = 4'd12,
    S_JAL       = 4'd13,
    S_JR        = 4'd14
  } state_e;

  // Write register select
  localparam logic [1:0] REG_DST_RT = 2'b00;
  localparam logic [1:0] REG_DST_RD = 2'b01;
  localparam logic [1:0] REG_DST_RA = 2'b10;

  // Write data select
  localparam logic [1:0] MEM_TO_REG_ALU = 2'b00;
  localparam logic [1:0] MEM_TO_REG_MDR = 2'b01;
  localparam logic [1:0] MEM_TO_REG_PC  = 2'b10;

  // ALU B input select
  localparam logic [1:0] ALU_B_REG    = 2'b00;
  localparam logic [1:0] ALU_B_FOUR   = 2'b01;
  localparam logic [1:0] ALU_B_IMM    = 2'b10;
  localparam logic [1:0] ALU_B_IMM_SH = 2'b11;

  // Next PC select
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_REG    = 2'b11;

endpackage

// File: rtl/multicycle_controller_alu_controller.sv
// ALU operation decoder shared with the single-cycle control unit:
// fixed ops for add/sub/slt classes, function-field decode for R-type.
module alu_controller
  import multicycle_controller_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] func,
  output logic [2:0] operation
);

  // Map ALU op class (and func for R-type) to the ALU operation code
  always_comb begin
    operation = ALU_ADD;
    case (alu_op)
      ALU_OP_ADD: operation = ALU_ADD;
      ALU_OP_SUB: operation = ALU_SUB;
      ALU_OP_SLT: operation = ALU_SLT;
      default: begin
        case (func)
          FUNC_ADD: operation = ALU_ADD;
          FUNC_SUB: operation = ALU_SUB;
          FUNC_AND: operation = ALU_AND;
          FUNC_OR:  operation = ALU_OR;
          FUNC_SLT: operation = ALU_SLT;
          default:  operation = ALU_ADD;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Moore controller for the multicycle MIPS datapath. All enables and
// selects decode from the current state; pc_load also folds in zero for
// branches. While rst is high the outputs show FETCH with every write
// enable and instr_done held low.
module multicycle_controller
  import multicycle_controller_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       zero,
  output logic       pc_load,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] operation,
  output logic       instr_done,
  output state_e     dbg_state_o
);

  state_e     state_q, state_d;
  state_e     out_state;
  logic [1:0] alu_op;
  logic       pc_write, pc_write_cond;
  logic       known_op;

  assign dbg_state_o = state_q;

  // opcode is only consulted from DECODE onward
  assign known_op = opcode inside {OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI,
                                   OP_SLTI, OP_J, OP_JAL, OP_JR};

  // State register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_FETCH;
    else     state_q <= state_d;
  end

  // Next-state and output decode
  always_comb begin
    state_d       = state_q;
    out_state     = rst ? S_FETCH : state_q;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = REG_DST_RT;
    mem_to_reg    = MEM_TO_REG_ALU;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = ALU_B_REG;
    pc_src        = PC_SRC_ALU;
    alu_op        = ALU_OP_ADD;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    instr_done    = 1'b0;
    pc_load       = 1'b0;

    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_RTYPE:     state_d = S_R_EXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_ADDI:      state_d = S_ADDI_EXEC;
          OP_SLTI:      state_d = S_SLTI_EXEC;
          OP_J:         state_d = S_JUMP;
          OP_JAL:       state_d = S_JAL;
          OP_JR:        state_d = S_JR;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:    state_d = S_LW_WB;
      S_R_EXEC:    state_d = S_R_WB;
      S_ADDI_EXEC: state_d = S_I_WB;
      S_SLTI_EXEC: state_d = S_I_WB;
      default:     state_d = S_FETCH;
    endcase

    case (out_state)
      S_FETCH: begin
        mem_read  = 1'b1;
        ir_write  = 1'b1;
        alu_src_b = ALU_B_FOUR;
        pc_write  = 1'b1;
      end
      S_DECODE: begin
        alu_src_b  = ALU_B_IMM_SH;
        instr_done = !known_op;
      end
      S_MEM_ADDR, S_ADDI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
      end
      S_SLTI_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = ALU_B_IMM;
        alu_op    = ALU_OP_SLT;
      end
      S_MEM_RD: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      S_LW_WB: begin
        mem_to_reg = MEM_TO_REG_MDR;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_MEM_WR: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_OP_FUNC;
      end
      S_R_WB: begin
        reg_dst    = REG_DST_RD;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_I_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_OP_SUB;
        pc_src        = PC_SRC_ALUOUT;
        pc_write_cond = 1'b1;
        instr_done    = 1'b1;
      end
      S_JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_src     = PC_SRC_JUMP;
        pc_write   = 1'b1;
        reg_dst    = REG_DST_RA;
        mem_to_reg = MEM_TO_REG_PC;
        reg_write  = 1'b1;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_src     = PC_SRC_REG;
        pc_write   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase

    pc_load = pc_write | (pc_write_cond & zero);

    if (rst) begin
      pc_load    = 1'b0;
      ir_write   = 1'b0;
      reg_write  = 1'b0;
      mem_write  = 1'b0;
      instr_done = 1'b0;
    end
  end

  alu_controller u_alu_controller (
    .alu_op    (alu_op),
    .func      (func),
    .operation (operation)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: each instruction is expanded into its
// expected per-cycle output timeline, queued, and compared against the
// DUT on every falling edge. Directed instructions follow the test plan,
// then a randomized instruction stream with occasional mid-instruction reset.
module tb_multicycle_controller;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [5:0] opcode, func;
  logic       zero;
  logic       pc_load, iord, mem_read, mem_write, ir_write, reg_write;
  logic       alu_src_a, instr_done;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [2:0] operation;
  logic [3:0] dbg_state;

  multicycle_controller dut (
    .clk         (clk),
    .rst         (rst),
    .opcode      (opcode),
    .func        (func),
    .zero        (zero),
    .pc_load     (pc_load),
    .iord        (iord),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .ir_write    (ir_write),
    .reg_dst     (reg_dst),
    .mem_to_reg  (mem_to_reg),
    .reg_write   (reg_write),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .pc_src      (pc_src),
    .operation   (operation),
    .instr_done  (instr_done),
    .dbg_state_o (dbg_state)
  );

  // Bit layout: [18]pc_load [17]iord [16]mem_read [15]mem_write [14]ir_write
  // [13:12]reg_dst [11:10]mem_to_reg [9]reg_write [8]alu_src_a [7:6]alu_src_b
  // [5:4]pc_src [3:1]operation [0]instr_done
  logic [18:0] dut_vec;
  assign dut_vec = {pc_load, iord, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, pc_src,
                    operation, instr_done};

  // ---------------- reference model ----------------
  localparam logic [5:0] T_R = 6'b000000, T_LW = 6'b100011, T_SW = 6'b101011;
  localparam logic [5:0] T_BEQ = 6'b000100, T_ADDI = 6'b001001, T_SLTI = 6'b001010;
  localparam logic [5:0] T_J = 6'b000010, T_JAL = 6'b000011, T_JR = 6'b000110;

  function automatic logic [18:0] mk(input logic pcl, input logic io, input logic mr,
                                     input logic mw, input logic irw, input logic [1:0] rd,
                                     input logic [1:0] m2r, input logic rw, input logic sa,
                                     input logic [1:0] sb, input logic [1:0] ps,
                                     input logic [2:0] op, input logic done);
    return {pcl, io, mr, mw, irw, rd, m2r, rw, sa, sb, ps, op, done};
  endfunction

  // FETCH-looking outputs with all write enables and done held low
  function automatic logic [18:0] reset_vec();
    return mk(0, 0, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 3'b010, 0);
  endfunction

  function automatic logic [2:0] func_op(input logic [5:0] fn);
    case (fn)
      6'b100000: return 3'b010;
      6'b100010: return 3'b110;
      6'b100100: return 3'b000;
      6'b100101: return 3'b001;
      6'b101010: return 3'b111;
      default:   return 3'b010;
    endcase
  endfunction

  function automatic int instr_len(input logic [5:0] op);
    case (op)
      T_LW:                        return 5;
      T_R, T_SW, T_ADDI, T_SLTI:   return 4;
      T_BEQ, T_J, T_JAL, T_JR:     return 3;
      default:                     return 2;
    endcase
  endfunction

  // Expected outputs in cycle k (0 = fetch) of an instruction
  function automatic logic [18:0] step_vec(input logic [5:0] op, input int k,
                                           input logic [5:0] fn, input logic z);
    logic last;
    last = (k == instr_len(op) - 1);
    if (k == 0) return mk(1, 0, 1, 0, 1, 2'b00, 2'b00, 0, 0, 2'b01, 2'b00, 3'b010, 0);
    if (k == 1) return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b11, 2'b00, 3'b010, last);
    case (op)
      T_LW, T_SW: begin
        if (k == 2) return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00, 3'b010, 0);
        if (op == T_SW) return mk(0, 1, 0, 1, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 3'b010, 1);
        if (k == 3) return mk(0, 1, 1, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b00, 3'b010, 0);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b01, 1, 0, 2'b00, 2'b00, 3'b010, 1);
      end
      T_R: begin
        if (k == 2) return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b00, func_op(fn), 0);
        return mk(0, 0, 0, 0, 0, 2'b01, 2'b00, 1, 0, 2'b00, 2'b00, 3'b010, 1);
      end
      T_ADDI, T_SLTI: begin
        if (k == 2) return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b10, 2'b00,
                              (op == T_SLTI) ? 3'b111 : 3'b010, 0);
        return mk(0, 0, 0, 0, 0, 2'b00, 2'b00, 1, 0, 2'b00, 2'b00, 3'b010, 1);
      end
      T_BEQ: return mk(z, 0, 0, 0, 0, 2'b00, 2'b00, 0, 1, 2'b00, 2'b01, 3'b110, 1);
      T_J:   return mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b10, 3'b010, 1);
      T_JAL: return mk(1, 0, 0, 0, 0, 2'b10, 2'b10, 1, 0, 2'b00, 2'b10, 3'b010, 1);
      T_JR:  return mk(1, 0, 0, 0, 0, 2'b00, 2'b00, 0, 0, 2'b00, 2'b11, 3'b010, 1);
      default: return '0;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [18:0] exp_q[$];
  string       name_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc_cnt = 0, last_len = 0, done_cnt = 0, rw_cnt = 0;
  logic [18:0] snap[8];

  task automatic check(input string nm, input logic [18:0] act, input logic [18:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Compare process: one expected vector per cycle, sampled mid-cycle
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [18:0] e;
      string       n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      check(n, dut_vec, e);
    end
    cyc_cnt++;
    if (rw_cnt >= 0 && reg_write) rw_cnt++;
    if (rst) cyc_cnt = 0;
    else if (instr_done) begin
      last_len = cyc_cnt;
      done_cnt++;
      cyc_cnt = 0;
    end
  end

  // ---------------- driver ----------------
  // zmode 0/1 holds zero fixed, 2 randomizes it every cycle;
  // abort_at >= 0 raises rst in that cycle of the instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                           input int zmode, input int abort_at);
    int len;
    len = instr_len(op);
    for (int k = 0; k < len; k++) begin
      @(posedge clk);
      #1;
      rst    = (k == abort_at);
      opcode = (k == 0) ? 6'($urandom) : op;
      func   = (k == 0) ? 6'($urandom) : fn;
      zero   = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
      exp_q.push_back(rst ? reset_vec() : step_vec(op, k, fn, zero));
      name_q.push_back($sformatf("cycle k%0d op %b%s", k, op, rst ? " rst" : ""));
      #2 snap[k] = dut_vec;
      if (rst) break;
    end
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 11))
      0: return T_R;     1: return T_LW;    2: return T_SW;
      3: return T_BEQ;   4: return T_ADDI;  5: return T_SLTI;
      6: return T_J;     7: return T_JAL;   8: return T_JR;
      9: return 6'b111111;
      10: return 6'b001000;
      default: return T_R;
    endcase
  endfunction

  function automatic logic [5:0] pick_func();
    case ($urandom_range(0, 4))
      0: return 6'b100000; 1: return 6'b100010; 2: return 6'b100100;
      3: return 6'b100101; default: return 6'b101010;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    int d0, rw0;
    rst = 1'b1; zero = 1'b0; opcode = '0; func = '0;

    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      exp_q.push_back(reset_vec());
      name_q.push_back("reset");
      #2;
      check("rst_pc_load", 19'(pc_load), 19'(0));
      check("rst_mem_read", 19'(mem_read), 19'(1));
      check("rst_ir_write", 19'(ir_write), 19'(1'b0));
    end

    // R-type add
    d0 = done_cnt;
    run_instr(T_R, 6'b100000, 2, -1);
    #3;
    check("first_fetch_pc_load", 19'(snap[0][18]), 19'(1));
    check("first_fetch_ir_write", 19'(snap[0][14]), 19'(1));
    check("add_len", 19'(last_len), 19'(4));
    check("add_exec_operation", 19'(snap[2][3:1]), 19'(3'b010));
    check("add_wb_reg_dst", 19'(snap[3][13:12]), 19'(2'b01));
    check("add_wb_reg_write", 19'(snap[3][9]), 19'(1));
    check("add_done_pulses", 19'(done_cnt - d0), 19'(1));

    // lw then sw
    run_instr(T_LW, 6'd0, 2, -1);
    #3;
    check("lw_len", 19'(last_len), 19'(5));
    check("lw_memrd_iord", 19'(snap[3][17]), 19'(1));
    check("lw_memrd_mem_read", 19'(snap[3][16]), 19'(1));
    run_instr(T_SW, 6'd0, 2, -1);
    #3;
    check("sw_len", 19'(last_len), 19'(4));
    check("sw_memwr_mem_write", 19'(snap[3][15]), 19'(1));
    check("sw_addr_mem_write", 19'(snap[2][15]), 19'(0));

    // beq taken / not taken
    run_instr(T_BEQ, 6'd0, 1, -1);
    #3;
    check("beq1_len", 19'(last_len), 19'(3));
    check("beq1_operation", 19'(snap[2][3:1]), 19'(3'b110));
    check("beq1_pc_src", 19'(snap[2][5:4]), 19'(2'b01));
    check("beq1_pc_load", 19'(snap[2][18]), 19'(1));
    run_instr(T_BEQ, 6'd0, 0, -1);
    #3;
    check("beq0_len", 19'(last_len), 19'(3));
    check("beq0_pc_load", 19'(snap[2][18]), 19'(0));

    // jal, jr, unknown opcode
    run_instr(T_JAL, 6'd0, 2, -1);
    #3;
    check("jal_reg_dst", 19'(snap[2][13:12]), 19'(2'b10));
    check("jal_mem_to_reg", 19'(snap[2][11:10]), 19'(2'b10));
    check("jal_pc_src", 19'(snap[2][5:4]), 19'(2'b10));
    run_instr(T_JR, 6'd0, 2, -1);
    #3;
    check("jr_pc_src", 19'(snap[2][5:4]), 19'(2'b11));
    run_instr(6'b111111, 6'd0, 2, -1);
    #3;
    check("bad_len", 19'(last_len), 19'(2));
    check("bad_write_enables", 19'({snap[1][18], snap[1][15], snap[1][14], snap[1][9]}), 19'(0));

    // reset during MEM_RD of lw, followed by a jump
    rw0 = rw_cnt;
    run_instr(T_LW, 6'd0, 2, 3);
    run_instr(T_J, 6'd0, 2, -1);
    #3;
    check("abort_lw_no_reg_write", 19'(rw_cnt - rw0), 19'(0));
    check("after_abort_len", 19'(last_len), 19'(3));

    // randomized instruction stream
    for (int n = 0; n < 400; n++) begin
      logic [5:0] op;
      int ab;
      op = pick_op();
      ab = ($urandom_range(0, 9) == 0) ? $urandom_range(0, instr_len(op) - 1) : -1;
      run_instr(op, pick_func(), 2, ab);
    end

    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
    check("queue_drained", 19'(exp_q.size()), 19'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
